// File: rtl/actuator_driver.sv
// actuator_driver: timed door/buzzer/climate drive from one-hot commands; climate watchdog built only with ACTUATOR_WATCHDOG_EN
module actuator_driver #(
   parameter int CNT_W      = 8,
   parameter int DOOR_HOLD  = 8,
   parameter int BUZZ_HALF  = 4,
   parameter int MIN_ON     = 16,
   parameter int DEAD_TIME  = 4,
   parameter int WDOG_LIMIT = 200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       front_door,
   input  logic       rear_door,
   input  logic       alarm_buzzer,
   input  logic       window_buzzer,
   input  logic       heater,
   input  logic       cooler,
   output logic       front_unlock,
   output logic       rear_unlock,
   output logic       alarm_drive,
   output logic       window_drive,
   output logic       heater_on,
   output logic       cooler_on,
   output logic [1:0] climate_state,
   output logic       cmd_error,
   output logic       wdog_trip
);
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] HEAT = 2'b01;
   localparam logic [1:0] COOL = 2'b10;
   localparam logic [1:0] DEAD = 2'b11;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DOOR_LD = CNT_W'(DOOR_HOLD);
   localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BUZZ_HALF - 1);
   // On/dead timers are loaded one short: the transition fires on the edge after they hit zero
   localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0] DT_LD   = CNT_W'(DEAD_TIME - 1);

   logic [5:0] cmd_raw, cmd;
   logic       multi;
   logic [1:0][CNT_W-1:0] hold_q, hold_d, phase_q, phase_d;
   logic [1:0] unlock_q, unlock_d, drive_q, drive_d, act_q, act_d;
   logic [1:0] state_q, state_d;
   logic [CNT_W-1:0] ctmr_q, ctmr_d;
   logic heat_q, cool_q, err_q, trip_q, wd_hit, req;

   // Any two or more simultaneous commands void the whole command word for this cycle
   assign cmd_raw = {cooler, heater, window_buzzer, alarm_buzzer, rear_door, front_door};
   assign multi   = (cmd_raw & (cmd_raw - 6'd1)) != 6'd0;
   assign cmd     = multi ? 6'd0 : cmd_raw;
   assign req     = (state_q == HEAT) ? cmd[4] : cmd[5];

`ifdef ACTUATOR_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WD_LD = CNT_W'(WDOG_LIMIT - 1);
   logic [CNT_W-1:0] res_q;
   logic             in_run;
   assign in_run = (state_q == HEAT) || (state_q == COOL);
   assign wd_hit = in_run && (res_q == WD_LD);
   // Residency counter for HEAT/COOL; the trip flag latches until reset
   always_ff @(posedge clk) begin
      if (reset) begin
         res_q  <= '0;
         trip_q <= 1'b0;
      end else begin
         res_q  <= (in_run && !wd_hit) ? res_q + ONE : '0;
         trip_q <= trip_q | wd_hit;
      end
   end
`else
   assign wd_hit = 1'b0;
   assign trip_q = 1'b0;
`endif

   // Door hold timers and buzzer tone generators, one instance per channel
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         hold_d[i]   = cmd[i] ? DOOR_LD : (hold_q[i] != '0 ? hold_q[i] - ONE : '0);
         unlock_d[i] = cmd[i] || (hold_q[i] != '0);
         act_d[i]    = cmd[i+2];
         phase_d[i]  = !cmd[i+2] ? '0 : (!act_q[i] || phase_q[i] == '0) ? HALF_LD : phase_q[i] - ONE;
         drive_d[i]  = !cmd[i+2] ? 1'b0 : !act_q[i] ? 1'b1 : (phase_q[i] == '0) ? !drive_q[i] : drive_q[i];
      end
   end

   // Climate FSM: minimum on-time, dead-time between states, optional watchdog exit
   always_comb begin
      state_d = state_q;
      ctmr_d  = ctmr_q;
      if (state_q == IDLE) begin
         if (!trip_q && cmd[4]) begin
            state_d = HEAT;
            ctmr_d  = ON_LD;
         end else if (!trip_q && cmd[5]) begin
            state_d = COOL;
            ctmr_d  = ON_LD;
         end
      end else if (state_q == DEAD) begin
         if (ctmr_q == '0) state_d = IDLE;
         else ctmr_d = ctmr_q - ONE;
      end else if (wd_hit || (ctmr_q == '0 && !req)) begin
         state_d = DEAD;
         ctmr_d  = DT_LD;
      end else if (ctmr_q != '0) begin
         ctmr_d = ctmr_q - ONE;
      end
   end

   // All state and output registers; reset overrides everything
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q   <= '0;
         phase_q  <= '0;
         unlock_q <= '0;
         drive_q  <= '0;
         act_q    <= '0;
         state_q  <= IDLE;
         ctmr_q   <= '0;
         heat_q   <= 1'b0;
         cool_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         hold_q   <= hold_d;
         phase_q  <= phase_d;
         unlock_q <= unlock_d;
         drive_q  <= drive_d;
         act_q    <= act_d;
         state_q  <= state_d;
         ctmr_q   <= ctmr_d;
         heat_q   <= state_d == HEAT;
         cool_q   <= state_d == COOL;
         err_q    <= multi;
      end
   end

   assign front_unlock  = unlock_q[0];
   assign rear_unlock   = unlock_q[1];
   assign alarm_drive   = drive_q[0];
   assign window_drive  = drive_q[1];
   assign heater_on     = heat_q;
   assign cooler_on     = cool_q;
   assign climate_state = state_q;
   assign cmd_error     = err_q;
   assign wdog_trip     = trip_q;
endmodule

// File: tb/tb_actuator_driver.sv
// tb_actuator_driver: directed stimulus, cycle-difference reference model and literal spot checks for actuator_driver
module tb_actuator_driver;
   localparam int DOOR_HOLD = 8, BUZZ_HALF = 4, MIN_ON = 16, DEAD_TIME = 4, WDOG_LIMIT = 200;

   logic clk = 1'b0, reset = 1'b1;
   logic front_door = 0, rear_door = 0, alarm_buzzer = 0, window_buzzer = 0, heater = 0, cooler = 0;
   logic front_unlock, rear_unlock, alarm_drive, window_drive, heater_on, cooler_on, cmd_error, wdog_trip;
   logic [1:0] climate_state;
   int checks = 0, errors = 0;

   actuator_driver #(.CNT_W(8), .DOOR_HOLD(DOOR_HOLD), .BUZZ_HALF(BUZZ_HALF), .MIN_ON(MIN_ON),
                     .DEAD_TIME(DEAD_TIME), .WDOG_LIMIT(WDOG_LIMIT)) dut (
      .clk(clk), .reset(reset), .front_door(front_door), .rear_door(rear_door),
      .alarm_buzzer(alarm_buzzer), .window_buzzer(window_buzzer), .heater(heater), .cooler(cooler),
      .front_unlock(front_unlock), .rear_unlock(rear_unlock), .alarm_drive(alarm_drive),
      .window_drive(window_drive), .heater_on(heater_on), .cooler_on(cooler_on),
      .climate_state(climate_state), .cmd_error(cmd_error), .wdog_trip(wdog_trip));

   always #5 clk = ~clk;

   // Reference model: outputs derived from elapsed cycles since the relevant command/state entry
   bit m_valid = 0, pa, pw, trip;
   int cyc, last_f, last_r, st_a, st_w, ent, ms;
   bit e_f, e_r, e_a, e_w, e_h, e_c, e_err;
   logic [1:0] e_cs;
   always @(posedge clk) begin : model
      int n;
      bit fd, rd, ab, wb, ht, cl, rq;
      if (reset) begin
         cyc = 0; last_f = -1000; last_r = -1000; st_a = 0; st_w = 0; pa = 0; pw = 0;
         ms = 0; ent = 0; trip = 0;
         {e_f, e_r, e_a, e_w, e_h, e_c, e_err} = '0;
         e_cs = 2'd0;
         m_valid = 1;
      end else begin
         cyc++;
         n = int'(front_door) + int'(rear_door) + int'(alarm_buzzer) + int'(window_buzzer) + int'(heater) + int'(cooler);
         e_err = n > 1;
         fd = n == 1 && front_door; rd = n == 1 && rear_door;
         ab = n == 1 && alarm_buzzer; wb = n == 1 && window_buzzer;
         ht = n == 1 && heater; cl = n == 1 && cooler;
         if (fd) last_f = cyc;
         if (rd) last_r = cyc;
         e_f = cyc - last_f <= DOOR_HOLD;
         e_r = cyc - last_r <= DOOR_HOLD;
         if (ab && !pa) st_a = cyc;
         if (wb && !pw) st_w = cyc;
         e_a = ab && ((cyc - st_a) / BUZZ_HALF) % 2 == 0;
         e_w = wb && ((cyc - st_w) / BUZZ_HALF) % 2 == 0;
         pa = ab; pw = wb;
         if (ms == 0) begin
            if (!trip && ht) begin ms = 1; ent = cyc; end
            else if (!trip && cl) begin ms = 2; ent = cyc; end
         end else if (ms == 3) begin
            if (cyc - ent >= DEAD_TIME) ms = 0;
         end else begin
            rq = (ms == 1) ? ht : cl;
`ifdef ACTUATOR_WATCHDOG_EN
            if (cyc - ent >= WDOG_LIMIT) begin ms = 3; ent = cyc; trip = 1; end
            else
`endif
            if (cyc - ent >= MIN_ON && !rq) begin ms = 3; ent = cyc; end
         end
         e_h = ms == 1; e_c = ms == 2; e_cs = 2'(ms);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp();
      chk("front_unlock", 32'(front_unlock), 32'(e_f));
      chk("rear_unlock", 32'(rear_unlock), 32'(e_r));
      chk("alarm_drive", 32'(alarm_drive), 32'(e_a));
      chk("window_drive", 32'(window_drive), 32'(e_w));
      chk("heater_on", 32'(heater_on), 32'(e_h));
      chk("cooler_on", 32'(cooler_on), 32'(e_c));
      chk("climate_state", 32'(climate_state), 32'(e_cs));
      chk("cmd_error", 32'(cmd_error), 32'(e_err));
      chk("wdog_trip", 32'(wdog_trip), 32'(trip));
      chk("interlock", 32'(heater_on & cooler_on), 0);
   endtask

   task automatic step();
      @(negedge clk);
      if (m_valid) cmp();
   endtask

   function automatic logic [31:0] all_out();
      return 32'({front_unlock, rear_unlock, alarm_drive, window_drive, heater_on, cooler_on,
                  climate_state, cmd_error, wdog_trip});
   endfunction

   initial begin
      int cnt, rcnt, hcnt, dcnt, first_c, last_h;
      logic [19:0] pat;
      logic [1:0] cs_rec [30];
      step(); step();
      reset = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_outputs", all_out(), 0);
      end
      front_door = 1; step(); front_door = 0;
      cnt = int'(front_unlock); rcnt = int'(rear_unlock);
      for (int i = 0; i < 11; i++) begin
         step(); cnt += int'(front_unlock); rcnt += int'(rear_unlock);
      end
      chk("front_hold_cycles", 32'(cnt), 9);
      chk("rear_stays_low", 32'(rcnt), 0);
      rear_door = 1; step(); rear_door = 0;
      cnt = int'(rear_unlock);
      step(); step(); step();
      cnt += 3 * int'(rear_unlock);
      rear_door = 1; step(); rear_door = 0; cnt += int'(rear_unlock);
      for (int i = 0; i < 10; i++) begin step(); cnt += int'(rear_unlock); end
      chk("rear_reload_cycles", 32'(cnt), 13);
      alarm_buzzer = 1; pat = '0;
      for (int i = 0; i < 20; i++) begin step(); pat = {pat[18:0], alarm_drive}; end
      alarm_buzzer = 0; step();
      chk("alarm_pattern", 32'(pat), 32'h000F0F0F);
      chk("alarm_release", 32'(alarm_drive), 0);
      window_buzzer = 1; for (int i = 0; i < 6; i++) step();
      chk("window_second_half", 32'(window_drive), 0);
      window_buzzer = 0; step();
      heater = 1; hcnt = 0; dcnt = 0; first_c = -1; last_h = -1;
      for (int i = 0; i < 30; i++) begin
         step();
         cs_rec[i] = climate_state;
         hcnt += int'(heater_on); dcnt += int'(climate_state == 2'b11);
         if (heater_on) last_h = i;
         if (cooler_on && first_c < 0) first_c = i;
         if (i == 1) begin heater = 0; cooler = 1; end
      end
      chk("heater_on_cycles", 32'(hcnt), 16);
      chk("dead_cycles", 32'(dcnt), 4);
      chk("state_heat", 32'(cs_rec[15]), 1);
      chk("state_dead", 32'(cs_rec[16]), 3);
      chk("state_idle", 32'(cs_rec[20]), 0);
      chk("state_cool", 32'(cs_rec[21]), 2);
      chk("drive_gap", 32'(first_c - last_h - 1), 5);
      cooler = 0;
      for (int i = 0; i < 30; i++) step();
      chk("cool_back_idle", 32'(climate_state), 0);
      heater = 1; cooler = 1; step();
      chk("both_cmd_error", 32'(cmd_error), 1);
      chk("both_stays_idle", 32'(climate_state), 0);
      heater = 0; cooler = 0; front_door = 1; alarm_buzzer = 1; step();
      chk("pair_cmd_error", 32'(cmd_error), 1);
      chk("pair_no_unlock", 32'(front_unlock), 0);
      front_door = 0; alarm_buzzer = 0; step();
      chk("error_clears", 32'(cmd_error), 0);
      heater = 1; step(); step(); heater = 0;
      chk("mid_heat", 32'(climate_state), 1);
      reset = 1; step();
      chk("reset_mid_heat", all_out(), 0);
      reset = 0; step();
      chk("after_reset", all_out(), 0);
`ifdef ACTUATOR_WATCHDOG_EN
      heater = 1;
      for (int i = 0; i < 250; i++) begin
         step();
         if (i == 199) chk("wd_still_heat", 32'(climate_state), 1);
         if (i == 200) chk("wd_dead", 32'(climate_state), 3);
         if (i == 200) chk("wd_trip_set", 32'(wdog_trip), 1);
      end
      chk("wd_heater_off", 32'(heater_on), 0);
      chk("wd_idle_locked", 32'(climate_state), 0);
      chk("wd_sticky", 32'(wdog_trip), 1);
      heater = 0; reset = 1; step(); reset = 0; step();
      chk("wd_reset_clear", 32'(wdog_trip), 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
